// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: FWFT byte FIFO behind uart_rx, character-timeout timer,
// sticky status flags and a maskable interrupt towards the APB register file.
module uart_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cfg_en_i,
    input  logic [15:0]      cfg_div_i,
    input  logic [7:0]       cfg_tmo_i,
    input  logic [CNT_W-1:0] cfg_trg_i,
    input  logic [3:0]       cfg_irq_en_i,
    input  logic             cfg_flush_i,
    input  logic [3:0]       clr_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    input  logic             rx_err_i,
    output logic             rx_err_clr_o,
    input  logic             rd_en_i,
    output logic [7:0]       rd_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic [3:0]       flags_o,
    output logic             irq_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        T_IDLE,
        T_COUNT,
        T_EXPIRED
    } tmr_state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_acc;
    logic             overrun_set;
    logic             xfer;

    tmr_state_t       tmr_state;
    logic [15:0]      div_cnt;
    logic [7:0]       tmo_cnt;
    logic [7:0]       tmo_inc;
    logic             tick;
    logic             leave;
    logic             expire;

    logic             err_armed;
    logic             unused_clr;

    assign unused_clr = clr_i[0];
    assign rx_ready_o = 1'b1;
    assign count_o    = count;
    assign rd_data_o  = (count != '0) ? mem[rd_ptr] : 8'h00;

    // Push/pop qualification; a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        push        = rx_valid_i & cfg_en_i & ~cfg_flush_i;
        pop         = rd_en_i & (count != '0) & ~cfg_flush_i;
        full        = (count == CNT_W'(FIFO_DEPTH));
        push_acc    = push & (~full | pop);
        overrun_set = push & full & ~pop;
        xfer        = push_acc | pop;
        count_nxt   = count;
        if (cfg_flush_i) begin
            count_nxt = '0;
        end else if (push_acc && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push_acc) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (cfg_flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (push_acc) mem[wr_ptr] <= rx_data_i;
    end

    always_comb begin
        tick    = (div_cnt == cfg_div_i);
        tmo_inc = tmo_cnt + 8'd1;
        leave   = cfg_flush_i | ~cfg_en_i | (count_nxt == '0);
        expire  = (tmr_state == T_COUNT) & ~leave & ~xfer & tick
                  & (cfg_tmo_i != 8'd0) & (tmo_inc == cfg_tmo_i);
    end

    // Character-timeout timer: bit ticks from the divider, expiry after cfg_tmo_i quiet bit periods.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmr_state <= T_IDLE;
            div_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (tmr_state)
                T_IDLE: begin
                    div_cnt <= '0;
                    tmo_cnt <= '0;
                    if (!leave && cfg_tmo_i != 8'd0) tmr_state <= T_COUNT;
                end
                T_COUNT: begin
                    if (leave) begin
                        tmr_state <= T_IDLE;
                        div_cnt   <= '0;
                        tmo_cnt   <= '0;
                    end else if (xfer) begin
                        div_cnt <= '0;
                        tmo_cnt <= '0;
                    end else if (tick) begin
                        div_cnt <= '0;
                        if (expire) begin
                            tmr_state <= T_EXPIRED;
                            tmo_cnt   <= '0;
                        end else begin
                            tmo_cnt <= tmo_inc;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                T_EXPIRED: begin
                    div_cnt <= '0;
                    tmo_cnt <= '0;
                    if (leave)     tmr_state <= T_IDLE;
                    else if (xfer) tmr_state <= T_COUNT;
                end
                default: begin
                    tmr_state <= T_IDLE;
                    div_cnt   <= '0;
                    tmo_cnt   <= '0;
                end
            endcase
        end
    end

    // Flags (set beats clear), one-shot parity clear pulse and the registered interrupt.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flags_o      <= '0;
            irq_o        <= 1'b0;
            rx_err_clr_o <= 1'b0;
            err_armed    <= 1'b1;
        end else begin
            flags_o[0]   <= (cfg_trg_i != '0) & (count_nxt >= cfg_trg_i);
            flags_o[1]   <= expire      | (flags_o[1] & ~clr_i[1]);
            flags_o[2]   <= overrun_set | (flags_o[2] & ~clr_i[2]);
            flags_o[3]   <= rx_err_i    | (flags_o[3] & ~clr_i[3]);
            rx_err_clr_o <= rx_err_i & err_armed;
            err_armed    <= ~rx_err_i;
            irq_o        <= |(flags_o & cfg_irq_en_i);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_en;
    logic [15:0]   cfg_div;
    logic [7:0]    cfg_tmo;
    logic [CW-1:0] cfg_trg;
    logic [3:0]    cfg_irq_en;
    logic          cfg_flush;
    logic [3:0]    clr;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_err;
    logic          rx_err_clr;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic [CW-1:0] count;
    logic [3:0]    flags;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [3:0] m_flags;
    logic       m_irq;
    logic       m_clr;
    logic       m_armed;
    bit         m_active;
    bit         m_expired;
    int         m_idle;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cfg_en_i     (cfg_en),
        .cfg_div_i    (cfg_div),
        .cfg_tmo_i    (cfg_tmo),
        .cfg_trg_i    (cfg_trg),
        .cfg_irq_en_i (cfg_irq_en),
        .cfg_flush_i  (cfg_flush),
        .clr_i        (clr),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .rx_err_i     (rx_err),
        .rx_err_clr_o (rx_err_clr),
        .rd_en_i      (rd_en),
        .rd_data_o    (rd_data),
        .count_o      (count),
        .flags_o      (flags),
        .irq_o        (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flags   = '0;
        m_irq     = 1'b0;
        m_clr     = 1'b0;
        m_armed   = 1'b1;
        m_active  = 1'b0;
        m_expired = 1'b0;
        m_idle    = 0;
    endtask

    // One clock edge of the specified behaviour, from the currently applied inputs.
    task automatic model_step();
        int  sz;
        bit  full, push, pop, ovr, ev, nxt_active, fire;
        logic [3:0] nf;
        sz   = q.size();
        full = (sz == DEPTH);
        push = rx_valid && cfg_en && !cfg_flush;
        pop  = rd_en && (sz != 0) && !cfg_flush;
        ovr  = push && full && !pop;
        ev   = pop || (push && (!full || pop));
        if (cfg_flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push && (!full || pop)) q.push_back(rx_data);
        end
        fire       = 1'b0;
        nxt_active = cfg_en && !cfg_flush && (cfg_tmo != 0) && (q.size() != 0);
        if (!nxt_active) begin
            m_active = 1'b0; m_expired = 1'b0; m_idle = 0;
        end else if (!m_active || ev) begin
            m_active = 1'b1; m_expired = 1'b0; m_idle = 0;
        end else if (!m_expired) begin
            m_idle++;
            if (m_idle == (int'(cfg_div) + 1) * int'(cfg_tmo)) begin
                fire = 1'b1; m_expired = 1'b1;
            end
        end
        m_irq   = |(m_flags & cfg_irq_en);
        nf[0]   = (cfg_trg != 0) && (q.size() >= int'(cfg_trg));
        nf[1]   = fire   || (m_flags[1] && !clr[1]);
        nf[2]   = ovr    || (m_flags[2] && !clr[2]);
        nf[3]   = rx_err || (m_flags[3] && !clr[3]);
        m_flags = nf;
        m_clr   = rx_err && m_armed;
        m_armed = !rx_err;
    endtask

    // Apply current inputs for one cycle, compare all outputs after the edge, drop pulses.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(q.size()));
        check("rd_data", 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        check("flags", 32'(flags), 32'(m_flags));
        check("irq", 32'(irq), 32'(m_irq));
        check("err_clr", 32'(rx_err_clr), 32'(m_clr));
        rx_valid  = 1'b0;
        rd_en     = 1'b0;
        cfg_flush = 1'b0;
        clr       = 4'h0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cycle();
    endtask

    task automatic flush_with(input logic [15:0] div, input logic [7:0] tmo,
                              input logic [CW-1:0] trg, input logic [3:0] ien);
        cfg_flush  = 1'b1;
        cfg_div    = div;
        cfg_tmo    = tmo;
        cfg_trg    = trg;
        cfg_irq_en = ien;
        clr        = 4'hE;
        cycle();
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_count"}, 32'(count), 32'h0);
        check({tag, "_flags"}, 32'(flags), 32'h0);
        check({tag, "_irq"}, 32'(irq), 32'h0);
        check({tag, "_errclr"}, 32'(rx_err_clr), 32'h0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check({tag, "_ready"}, 32'(rx_ready), 32'h1);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; cfg_en = 1'b1; cfg_div = 16'd3; cfg_tmo = 8'd0; cfg_trg = '0;
        cfg_irq_en = 4'h0; cfg_flush = 1'b0; clr = 4'h0; rx_data = 8'h00;
        rx_valid = 1'b0; rx_err = 1'b0; rd_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_check("reset");
        rst_n = 1'b1;
        cycle();

        // Fill, overrun, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(8'hAA);
        check("t1_count_full", 32'(count), 32'd16);
        check("t1_overrun", 32'(flags[2]), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("t1_head", 32'(rd_data), 32'(i));
            rd_en = 1'b1;
            cycle();
        end
        check("t1_count_empty", 32'(count), 32'd0);
        check("t1_rd_zero", 32'(rd_data), 32'd0);
        clr = 4'h4;
        cycle();

        // Simultaneous push and pop while full
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        rx_data = 8'h55; rx_valid = 1'b1; rd_en = 1'b1;
        cycle();
        check("t2_count", 32'(count), 32'd16);
        check("t2_no_overrun", 32'(flags[2]), 32'h0);
        for (int i = 0; i < 16; i++) begin
            check("t2_head", 32'(rd_data), (i == 15) ? 32'h55 : 32'(8'h11 + i));
            rd_en = 1'b1;
            cycle();
        end

        // Threshold and interrupt
        flush_with(16'd3, 8'd0, CW'(4), 4'b0001);
        for (int i = 0; i < 4; i++) begin
            push_byte(8'(8'hC0 + i));
            if (i < 3) check("t3_thr_low", 32'(flags[0]), 32'h0);
        end
        check("t3_thr", 32'(flags[0]), 32'h1);
        check("t3_irq_lag", 32'(irq), 32'h0);
        cycle();
        check("t3_irq", 32'(irq), 32'h1);
        rd_en = 1'b1;
        cycle();
        check("t3_thr_clr", 32'(flags[0]), 32'h0);
        cycle();
        check("t3_irq_clr", 32'(irq), 32'h0);

        // Timeout window and restart
        flush_with(16'd3, 8'd4, CW'(0), 4'b0010);
        push_byte(8'h31);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            if (k == 15) check("t4_tmo_early", 32'(flags[1]), 32'h0);
        end
        check("t4_tmo", 32'(flags[1]), 32'h1);
        clr = 4'h2;
        cycle();
        check("t4_tmo_clr", 32'(flags[1]), 32'h0);
        flush_with(16'd3, 8'd4, CW'(0), 4'b0010);
        push_byte(8'h32);
        for (int k = 1; k <= 26; k++) begin
            if (k == 10) push_byte(8'h33);
            else cycle();
            if (k == 16) check("t4_restart_16", 32'(flags[1]), 32'h0);
            if (k == 25) check("t4_restart_25", 32'(flags[1]), 32'h0);
        end
        check("t4_restart_26", 32'(flags[1]), 32'h1);

        // Parity error held three cycles
        flush_with(16'd3, 8'd0, CW'(0), 4'h0);
        pulses = 0;
        rx_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (rx_err_clr) pulses++;
        end
        rx_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (rx_err_clr) pulses++;
        end
        check("t5_parity", 32'(flags[3]), 32'h1);
        check("t5_pulses", 32'(pulses), 32'd1);

        // Flush colliding with a push
        flush_with(16'd3, 8'd4, CW'(0), 4'h0);
        for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
        rx_data = 8'h77; rx_valid = 1'b1; cfg_flush = 1'b1;
        cycle();
        check("t6_count", 32'(count), 32'd0);
        check("t6_no_overrun", 32'(flags[2]), 32'h0);
        repeat (40) cycle();
        check("t6_no_tmo", 32'(flags[1]), 32'h0);

        // Randomized traffic
        for (int ph = 0; ph < 4; ph++) begin
            flush_with(16'($urandom_range(0, 3)), 8'($urandom_range(0, 5)),
                       CW'($urandom_range(0, 16)), 4'($urandom));
            for (int c = 0; c < 400; c++) begin
                rx_data    = 8'($urandom);
                rx_valid   = ($urandom_range(0, 99) < 45);
                rd_en      = ($urandom_range(0, 99) < 30);
                cfg_en     = ($urandom_range(0, 99) < 95);
                cfg_irq_en = 4'($urandom);
                cfg_trg    = ($urandom_range(0, 99) < 5) ? CW'($urandom_range(0, 16)) : cfg_trg;
                clr        = ($urandom_range(0, 99) < 10) ? 4'($urandom) : 4'h0;
                rx_err     = ($urandom_range(0, 99) < 8) ? ~rx_err : rx_err;
                cycle();
            end
            cfg_en = 1'b1;
            rx_err = 1'b0;
        end

        // Reset in the middle of traffic
        for (int i = 0; i < 6; i++) push_byte(8'(8'hE0 + i));
        rx_err = 1'b1;
        cycle();
        rst_n = 1'b0;
        rx_err = 1'b0;
        #2;
        reset_check("midreset");
        model_reset();
        @(posedge clk);
        #1;
        reset_check("midreset_hold");
        rst_n = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
